instr_encoder: RTL
==================

# instr_encoder

Streaming MIPS instruction encoder: the inverse of the datapath controller's decode. It accepts symbolic operations (op code plus register, immediate and target fields) over a valid/ready handshake and emits 32-bit MIPS instruction words tagged with their instruction-memory addresses. Words pass through a 2-entry output FIFO. The block sits between the test-program generator and the instruction-memory loader, and produces the ADD/SUB/ORI/LW/SW/BEQ/LUI/JAL/JR subset the CPU executes.

## Interface
- `PC_BASE`, default 32'h0000_3000: address of the first emitted word.
- `clk`  in  1: the only clock.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `in_valid`  in  1: an operation is presented.
- `in_ready`  out  1: the encoder accepts the operation on this edge.
- `in_op`  in  4: 0 ADD, 1 SUB, 2 ORI, 3 LW, 4 SW, 5 BEQ, 6 LUI, 7 JAL, 8 JR, 9 NOP; 10–15 illegal.
- `in_rs`, `in_rt`, `in_rd`  in  5 each: register fields.
- `in_imm`  in  16: immediate or offset field.
- `in_target`  in  26: jump target field.
- `out_valid`  out  1: the FIFO head is valid.
- `out_ready`  in  1: the sink consumes the head on this edge.
- `out_instr`  out  32: encoded word at the FIFO head.
- `out_addr`  out  32: address of that word.
- `err_cnt`  out  8: count of illegal ops, saturating.

## Operation
- Encodings:
  - ADD = {000000, rs, rt, rd, 00000, 100000}
  - SUB = the same with funct 100010
  - ORI = {001101, rs, rt, imm}
  - LW = {100011, rs, rt, imm}
  - SW = {101011, rs, rt, imm}
  - BEQ = {000100, rs, rt, imm}
  - LUI = {001111, 00000, rt, imm}
  - JAL = {000011, target}
  - JR = {000000, rs, 15'b0, 001000}
  - NOP = 32'h0
- Fields not used by an op are ignored.
- Handshake:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
  - `in_ready` = (FIFO count != 2) && state == IDLE. It is registered-state driven and has no combinational path from `out_ready`.
- Address counter `pc`:
  - Resets to `PC_BASE`.
  - Each pushed word takes the current `pc`; `pc` then increments by 4 and wraps modulo 2^32.
- Illegal op:
  - The handshake completes.
  - Nothing is pushed and `pc` is unchanged.
  - `err_cnt` increments and saturates at 255.
- FIFO:
  - 2 entries of {addr, instr}.
  - Push and pop in the same cycle are allowed at any count. At count 2, a pop frees a slot, but `in_ready` stays 0 in that cycle.
  - `out_instr` and `out_addr` read 0 while the FIFO is empty.
- State machine: IDLE, PAD. PAD is reachable only with the delay-slot padding macro `ENC_DELAY_SLOT_PAD_EN` defined (see Configuration).
  - IDLE → PAD: on acceptance of BEQ, JAL or JR.
  - PAD: `in_ready` = 0. When count < 2 (evaluated before that cycle's pop), push NOP at the current `pc`, then go to IDLE.
- Reset values: `in_ready` 1, `out_valid` 0, `out_instr` 0, `out_addr` 0, `err_cnt` 0, state IDLE, `pc` = `PC_BASE`, FIFO empty.

## Timing
- Latency: an op accepted at edge N appears at `out_valid`/`out_instr` after edge N (1 cycle) when the FIFO was empty.
- Throughput: one word per cycle while the sink keeps `out_ready` high.
- Under back-pressure, up to 2 words are held; `in_ready` then drops after the edge that fills the second entry.
- With padding enabled, branch and jump ops cost 2 slots. The NOP is pushed no earlier than the cycle after the branch is accepted.
- Reset asserted mid-operation:
  - All outputs take their reset values immediately (asynchronous).
  - A pending PAD is discarded.
  - After deassertion, the first accepted op is emitted at `PC_BASE`.

## Configuration
- `ENC_DELAY_SLOT_PAD_EN`:
  - Defined: the PAD state exists; every BEQ, JAL and JR is followed by an auto-inserted NOP at the next address.
  - Undefined: no PAD state, `in_ready` ignores state, and branches are emitted back-to-back like any other op.

## Test plan
- Encoding and base address: after reset, send ORI rs=0 rt=1 imm=0x1234, then ADD rs=1 rt=2 rd=3, with `out_ready`=1 → 0x34011234 @0x3000, then 0x00221820 @0x3004.
- Remaining encodings: send LUI rt=2 imm=0xABCD, JAL target=0xC03 and JR rs=31 → 0x3C02ABCD, 0x0C000C03 and 0x03E00008 at consecutive addresses. With padding enabled, each JAL and JR is additionally followed by 0x00000000.
- Back-pressure:
  - Hold `out_ready`=0 and send 3 ops. The first two are accepted; `in_ready`=0 from the cycle after the second acceptance until a pop.
  - Release `out_ready` → the words arrive in order with no loss or duplication.
- Illegal op: send in_op=12, then ORI → `err_cnt`=1, no word emitted for op 12, ORI @0x3000. Sending 300 illegal ops → `err_cnt`=255.
- Delay-slot pad (macro defined): send BEQ rs=1 rt=2 imm=3, then ADD → 0x10220003 @0x3000, 0x00000000 @0x3004, ADD @0x3008; `in_ready`=0 for one cycle after BEQ acceptance.
- Mid-stream reset: assert `reset` asynchronously with 2 words buffered → `out_valid`=0 at once. The next op after release is emitted @0x3000.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder
//   Streaming MIPS instruction encoder. It turns symbolic operations (op code
//   plus register, immediate and target fields) into 32-bit MIPS instruction
//   words. Each word is tagged with its instruction-memory address and passes
//   through a 2-entry output FIFO.
//
//   Optional feature macro: ENC_DELAY_SLOT_PAD_EN
//     When it is defined, every BEQ, JAL and JR is followed by an
//     auto-inserted NOP that fills the branch delay slot.
//
// Parameters
//   PC_BASE    address of the first emitted word
//
// Ports
//   clk        clock
//   reset      asynchronous, active-high reset
//   in_valid   an operation is presented
//   in_ready   the operation is accepted on this edge
//   in_op      0 ADD, 1 SUB, 2 ORI, 3 LW, 4 SW, 5 BEQ, 6 LUI, 7 JAL, 8 JR,
//              9 NOP; 10-15 are illegal
//   in_rs/in_rt/in_rd, in_imm, in_target   operation fields
//   out_valid  the FIFO head is valid
//   out_ready  the sink consumes the head on this edge
//   out_instr  encoded word at the FIFO head (0 when the FIFO is empty)
//   out_addr   address of that word (0 when the FIFO is empty)
//   err_cnt    saturating count of illegal ops
module instr_encoder #(
  parameter logic [31:0] PC_BASE = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic [7:0]  err_cnt
);

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpOri = 4'd2;
  localparam logic [3:0] OpLw  = 4'd3;
  localparam logic [3:0] OpSw  = 4'd4;
  localparam logic [3:0] OpBeq = 4'd5;
  localparam logic [3:0] OpLui = 4'd6;
  localparam logic [3:0] OpJal = 4'd7;
  localparam logic [3:0] OpJr  = 4'd8;
  localparam logic [3:0] OpNop = 4'd9;

  logic [31:0] encWord;
  logic        opLegal;
  logic        accept;
  logic        pop;
  logic        push;
  logic        padPush;
  logic [31:0] pushWord;
  logic [31:0] pc;

  logic [31:0] instrMem [2];
  logic [31:0] addrMem  [2];
  logic        wrPtr;
  logic        rdPtr;
  logic [1:0]  count;

  // NOTE: every signal written here gets a default first, so a missing case
  // arm can never infer a latch.
  always_comb begin
    encWord = 32'h0;
    opLegal = 1'b1;
    case (in_op)
      OpAdd:   encWord = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
      OpSub:   encWord = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
      OpOri:   encWord = {6'b001101, in_rs, in_rt, in_imm};
      OpLw:    encWord = {6'b100011, in_rs, in_rt, in_imm};
      OpSw:    encWord = {6'b101011, in_rs, in_rt, in_imm};
      OpBeq:   encWord = {6'b000100, in_rs, in_rt, in_imm};
      OpLui:   encWord = {6'b001111, 5'b00000, in_rt, in_imm};
      OpJal:   encWord = {6'b000011, in_target};
      OpJr:    encWord = {6'b000000, in_rs, 15'b0, 6'b001000};
      OpNop:   encWord = 32'h0;
      default: opLegal = 1'b0;
    endcase
  end

`ifdef ENC_DELAY_SLOT_PAD_EN
  typedef enum logic {IDLE, PAD} state_t;
  state_t stateQ, stateD;
  logic   isBranch;

  assign isBranch = (in_op == OpBeq) || (in_op == OpJal) || (in_op == OpJr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stateQ <= IDLE;
    else       stateQ <= stateD;
  end

  // The NOP waits in PAD until a slot is free; count is the pre-pop value,
  // so a full FIFO that pops this cycle still defers the NOP by one cycle.
  always_comb begin
    stateD  = stateQ;
    padPush = 1'b0;
    case (stateQ)
      IDLE: if (accept && isBranch) stateD = PAD;
      PAD: begin
        if (count != 2'd2) begin
          padPush = 1'b1;
          stateD  = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  assign in_ready = (count != 2'd2) && (stateQ == IDLE);
`else
  assign padPush  = 1'b0;
  assign in_ready = (count != 2'd2);
`endif

  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign push     = (accept && opLegal) || padPush;
  assign pushWord = padPush ? 32'h0 : encWord;

  assign out_valid = (count != 2'd0);
  assign out_instr = out_valid ? instrMem[rdPtr] : 32'h0;
  assign out_addr  = out_valid ? addrMem[rdPtr]  : 32'h0;

  // NOTE: the FIFO storage is not reset; the outputs are gated by count, so a
  // stale entry is never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      instrMem[wrPtr] <= pushWord;
      addrMem[wrPtr]  <= pc;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments, so
  // every register samples its pre-edge inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      count <= 2'd0;
      pc    <= PC_BASE;
    end else begin
      if (push) begin
        wrPtr <= ~wrPtr;
        pc    <= pc + 32'd4;
      end
      if (pop) rdPtr <= ~rdPtr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // An illegal op still completes its handshake; it only bumps the counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt <= 8'd0;
    end else if (accept && !opLegal && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
